// File: rtl/gp_reg_bank_pkg.sv
// Shared definitions for the general-purpose register bank with interrupt
// controller: register offsets above the GP window, CONFIG field positions
// and the byte-enable merge helper used for byte-writable registers.
package gp_reg_bank_pkg;

    // Word offsets relative to NUM_GP (the first address past the GP window).
    localparam int OFS_STATUS = 0;
    localparam int OFS_MASK   = 1;
    localparam int OFS_FORCE  = 2;
    localparam int OFS_CONFIG = 3;

    // CONFIG register field layout.
    localparam int CFG_NUM_GP_LSB = 0;
    localparam int CFG_IRQ_W_LSB  = 8;

    // Selects the new byte when its enable is set, otherwise keeps the old one.
    function automatic logic [7:0] be_merge8(
        input logic [7:0] old_byte,
        input logic [7:0] new_byte,
        input logic       en
    );
        return en ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/irq_edge_capture.sv
// Rising-edge interrupt capture with sticky status.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   irq_src       event inputs, synchronous to clk
//   clr           per-bit write-1-to-clear request (already byte-qualified)
//   set           per-bit software force request (already byte-qualified)
//   status        sticky status bits
module irq_edge_capture
    import gp_reg_bank_pkg::*;
#(
    parameter int IRQ_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IRQ_W-1:0] irq_src,
    input  logic [IRQ_W-1:0] clr,
    input  logic [IRQ_W-1:0] set,
    output logic [IRQ_W-1:0] status
);

    logic [IRQ_W-1:0] src_q;
    logic [IRQ_W-1:0] status_q;
    logic [IRQ_W-1:0] status_d;
    logic [IRQ_W-1:0] rise;

    // src_q resets to 0, so a source held high through reset is seen as an
    // edge at the first clock after release.
    assign rise = irq_src & ~src_q;

    // Clear is applied first and set terms are ORed afterwards, so a new
    // edge or force on the same bit as a W1C leaves the bit set.
    assign status_d = (status_q & ~clr) | rise | set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q    <= '0;
            status_q <= '0;
        end else begin
            src_q    <= irq_src;
            status_q <= status_d;
        end
    end

    assign status = status_q;

endmodule

// File: rtl/gp_reg_bank_irq.sv
// Memory-mapped bank of NUM_GP general-purpose registers plus a maskable,
// sticky interrupt controller on a simple read/write slave bus.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   read, write  single-cycle access strobes
//   address      word address; byte_en / write_data for writes
//   read_data    registered read data, holds between reads
//   gp_out       register i at [i*DATA_W +: DATA_W]
//   irq_src      hardware event inputs
//   irq          level interrupt, OR of (status & mask)
module gp_reg_bank_irq
    import gp_reg_bank_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int NUM_GP = 4,
    parameter int IRQ_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     read,
    input  logic                     write,
    input  logic [ADDR_W-1:0]        address,
    input  logic [DATA_W/8-1:0]      byte_en,
    input  logic [DATA_W-1:0]        write_data,
    output logic [DATA_W-1:0]        read_data,
    output logic [NUM_GP*DATA_W-1:0] gp_out,
    input  logic [IRQ_W-1:0]         irq_src,
    output logic                     irq
);

    localparam int NBYTES = DATA_W / 8;

    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(NUM_GP + OFS_STATUS);
    localparam logic [ADDR_W-1:0] A_MASK   = ADDR_W'(NUM_GP + OFS_MASK);
    localparam logic [ADDR_W-1:0] A_FORCE  = ADDR_W'(NUM_GP + OFS_FORCE);
    localparam logic [ADDR_W-1:0] A_CONFIG = ADDR_W'(NUM_GP + OFS_CONFIG);

    localparam logic [31:0] CFG32 = ((32'(NUM_GP) & 32'hFF) << CFG_NUM_GP_LSB)
                                  | ((32'(IRQ_W)  & 32'hFF) << CFG_IRQ_W_LSB);
    localparam logic [DATA_W-1:0] CFG_WORD = DATA_W'(CFG32);

    logic [DATA_W-1:0] be_bits;
    logic [IRQ_W-1:0]  mask_q;
    logic [IRQ_W-1:0]  mask_d;
    logic [IRQ_W-1:0]  status;
    logic [IRQ_W-1:0]  w1c_bits;
    logic [IRQ_W-1:0]  force_bits;
    logic [DATA_W-1:0] read_data_q;
    logic [DATA_W-1:0] read_data_d;

    // Expand byte enables to a per-bit mask.
    for (genvar gj = 0; gj < NBYTES; gj++) begin : gen_be
        assign be_bits[gj*8 +: 8] = {8{byte_en[gj]}};
    end

    // GP registers, one generate block each, byte-merged on write.
    for (genvar gi = 0; gi < NUM_GP; gi++) begin : gen_gp
        logic [DATA_W-1:0] gp_q;
        logic [DATA_W-1:0] gp_d;
        logic              gp_we;

        assign gp_we = write && (address == ADDR_W'(gi));

        for (genvar gj = 0; gj < NBYTES; gj++) begin : gen_byte
            assign gp_d[gj*8 +: 8] = gp_we
                ? be_merge8(gp_q[gj*8 +: 8], write_data[gj*8 +: 8], byte_en[gj])
                : gp_q[gj*8 +: 8];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                gp_q <= '0;
            end else begin
                gp_q <= gp_d;
            end
        end

        assign gp_out[gi*DATA_W +: DATA_W] = gp_q;
    end

    // Mask register holds only the implemented interrupt bits.
    always_comb begin
        mask_d = mask_q;
        if (write && (address == A_MASK)) begin
            mask_d = (mask_q & ~be_bits[IRQ_W-1:0])
                   | (write_data[IRQ_W-1:0] & be_bits[IRQ_W-1:0]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign w1c_bits   = (write && (address == A_STATUS))
                      ? (write_data[IRQ_W-1:0] & be_bits[IRQ_W-1:0]) : '0;
    assign force_bits = (write && (address == A_FORCE))
                      ? (write_data[IRQ_W-1:0] & be_bits[IRQ_W-1:0]) : '0;

    irq_edge_capture #(
        .IRQ_W (IRQ_W)
    ) u_irq_edge_capture (
        .clk     (clk),
        .rst     (rst),
        .irq_src (irq_src),
        .clr     (w1c_bits),
        .set     (force_bits),
        .status  (status)
    );

    // Read mux works on current register contents, so a same-cycle write to
    // the same address returns the pre-write value.
    always_comb begin
        read_data_d = '0;
        for (int i = 0; i < NUM_GP; i++) begin
            if (address == ADDR_W'(i)) begin
                read_data_d = gp_out[i*DATA_W +: DATA_W];
            end
        end
        if (address == A_STATUS) begin
            read_data_d[IRQ_W-1:0] = status;
        end
        if (address == A_MASK) begin
            read_data_d[IRQ_W-1:0] = mask_q;
        end
        if (address == A_CONFIG) begin
            read_data_d = CFG_WORD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data_q <= '0;
        end else if (read) begin
            read_data_q <= read_data_d;
        end
    end

    assign read_data = read_data_q;

    // Driven only by registers, never by bus inputs.
    assign irq = |(status & mask_q);

endmodule

// File: tb/tb_gp_reg_bank_irq.sv
module tb_gp_reg_bank_irq;

    logic          clk;
    logic          rst;
    logic          read;
    logic          write;
    logic [9:0]    address;
    logic [3:0]    byte_en;
    logic [31:0]   write_data;
    logic [31:0]   read_data;
    logic [127:0]  gp_out;
    logic [7:0]    irq_src;
    logic          irq;

    int n_checks;
    int n_errors;

    typedef struct {
        bit          wr;
        logic [9:0]  addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];

    gp_reg_bank_irq #(
        .DATA_W (32),
        .ADDR_W (10),
        .NUM_GP (4),
        .IRQ_W  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .read       (read),
        .write      (write),
        .address    (address),
        .byte_en    (byte_en),
        .write_data (write_data),
        .read_data  (read_data),
        .gp_out     (gp_out),
        .irq_src    (irq_src),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input bit wr, input logic [9:0] a, input logic [3:0] be,
                       input logic [31:0] d, input logic [31:0] e, input string nm);
        vec_t v;
        v.wr = wr; v.addr = a; v.be = be; v.data = d; v.exp = e; v.name = nm;
        vecs.push_back(v);
    endtask

    task automatic do_write(input logic [9:0] a, input logic [3:0] be, input logic [31:0] d);
        @(negedge clk);
        write = 1'b1; address = a; byte_en = be; write_data = d;
        @(posedge clk);
        #1;
        write = 1'b0;
        $display("wr addr=%0d be=%b data=0x%08h", a, be, d);
    endtask

    // Scoreboard: expectation pushed with the read strobe, popped when the
    // registered read data is due one edge later.
    task automatic do_read(input logic [9:0] a, input logic [31:0] e, input string nm);
        sb_t s;
        @(negedge clk);
        read = 1'b1; address = a;
        s.exp = e; s.name = nm;
        sb.push_back(s);
        @(posedge clk);
        #1;
        read = 1'b0;
        s = sb.pop_front();
        $display("rd addr=%0d data=0x%08h", a, read_data);
        check(s.name, read_data, s.exp);
    endtask

    // Read and write to the same address in one cycle.
    task automatic do_rw(input logic [9:0] a, input logic [31:0] d, input logic [31:0] e_old,
                         input string nm);
        sb_t s;
        @(negedge clk);
        read = 1'b1; write = 1'b1; address = a; byte_en = 4'hF; write_data = d;
        s.exp = e_old; s.name = nm;
        sb.push_back(s);
        @(posedge clk);
        #1;
        read = 1'b0; write = 1'b0;
        s = sb.pop_front();
        $display("rw addr=%0d wdata=0x%08h rdata=0x%08h", a, d, read_data);
        check(s.name, read_data, s.exp);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1; read = 1'b0; write = 1'b0; address = '0;
        byte_en = '0; write_data = '0; irq_src = '0;

        // Reset map, then GP byte-enable behaviour and ignored writes.
        add(0, 10'd0,    4'h0, 32'h0,        32'h0,          "rst_gp0");
        add(0, 10'd1,    4'h0, 32'h0,        32'h0,          "rst_gp1");
        add(0, 10'd2,    4'h0, 32'h0,        32'h0,          "rst_gp2");
        add(0, 10'd3,    4'h0, 32'h0,        32'h0,          "rst_gp3");
        add(0, 10'd4,    4'h0, 32'h0,        32'h0,          "rst_status");
        add(0, 10'd5,    4'h0, 32'h0,        32'h0,          "rst_mask");
        add(0, 10'd6,    4'h0, 32'h0,        32'h0,          "rst_force");
        add(0, 10'd7,    4'h0, 32'h0,        32'h0000_0804,  "rst_config");
        add(0, 10'd9,    4'h0, 32'h0,        32'h0,          "rst_addr9");
        add(0, 10'd1023, 4'h0, 32'h0,        32'h0,          "rst_addr1023");
        add(1, 10'd2,    4'hF, 32'h11223344, 32'h0,          "");
        add(1, 10'd2,    4'h5, 32'hDEADBEEF, 32'h0,          "");
        add(0, 10'd2,    4'h0, 32'h0,        32'h11AD33EF,   "gp2_be0101");
        add(1, 10'd0,    4'h8, 32'hA5A5A5A5, 32'h0,          "");
        add(0, 10'd0,    4'h0, 32'h0,        32'hA5000000,   "gp0_be1000");
        add(0, 10'd3,    4'h0, 32'h0,        32'h0,          "gp3_untouched");
        add(1, 10'd9,    4'hF, 32'hFFFFFFFF, 32'h0,          "");
        add(0, 10'd9,    4'h0, 32'h0,        32'h0,          "addr9_after_wr");
        add(1, 10'd7,    4'hF, 32'hFFFFFFFF, 32'h0,          "");
        add(0, 10'd7,    4'h0, 32'h0,        32'h0000_0804,  "config_ro");
        add(1, 10'd6,    4'h0, 32'hFFFFFFFF, 32'h0,          "");
        add(0, 10'd4,    4'h0, 32'h0,        32'h0,          "force_be0");

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_irq", {31'b0, irq}, 32'h0);
        check("rst_read_data", read_data, 32'h0);
        check("rst_gp_out_lo", gp_out[31:0], 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].be, vecs[i].data);
            else            do_read(vecs[i].addr, vecs[i].exp, vecs[i].name);
        end
        check("gp_out_gp2", gp_out[95:64], 32'h11AD33EF);
        check("gp_out_gp0", gp_out[31:0], 32'hA5000000);

        // read_data holds while read is low.
        do_read(10'd2, 32'h11AD33EF, "rd_gp2");
        @(negedge clk); address = 10'd7;
        @(posedge clk); #1;
        check("rd_hold", read_data, 32'h11AD33EF);

        // Same-cycle read and write returns the old value.
        do_rw(10'd1, 32'h12345678, 32'h0, "rw_old_value");
        do_read(10'd1, 32'h12345678, "rw_new_value");

        // Edge capture with mask off, then unmask, then W1C.
        @(negedge clk); irq_src = 8'h08;
        @(negedge clk); irq_src = 8'h00;
        do_read(10'd4, 32'h08, "edge_status");
        check("edge_irq_masked", {31'b0, irq}, 32'h0);
        do_write(10'd5, 4'hF, 32'h08);
        check("unmask_irq", {31'b0, irq}, 32'h1);
        do_write(10'd4, 4'h0, 32'h08);
        check("w1c_be0_irq", {31'b0, irq}, 32'h1);
        do_write(10'd4, 4'hF, 32'h08);
        check("w1c_irq", {31'b0, irq}, 32'h0);
        do_read(10'd4, 32'h0, "w1c_status");

        // W1C colliding with a new rising edge on the same bit: set wins.
        do_write(10'd5, 4'hF, 32'h0A);
        @(negedge clk); irq_src = 8'h02;
        @(negedge clk); irq_src = 8'h00;
        do_read(10'd4, 32'h02, "bit1_set");
        @(negedge clk);
        irq_src = 8'h02; write = 1'b1; address = 10'd4; byte_en = 4'hF; write_data = 32'h02;
        @(posedge clk); #1;
        write = 1'b0;
        $display("wr addr=4 be=1111 data=0x00000002 with irq_src rise");
        check("collide_irq", {31'b0, irq}, 32'h1);
        do_read(10'd4, 32'h02, "collide_status");
        @(negedge clk); irq_src = 8'h00;
        do_write(10'd4, 4'hF, 32'h02);
        do_read(10'd4, 32'h0, "collide_cleared");

        // Force sets status, reads zero; W1C clears only the written bit.
        do_write(10'd6, 4'hF, 32'h81);
        do_read(10'd4, 32'h81, "force_status");
        check("force_irq_masked", {31'b0, irq}, 32'h0);
        do_read(10'd6, 32'h0, "force_reads0");
        do_write(10'd4, 4'hF, 32'h01);
        do_read(10'd4, 32'h80, "force_w1c");

        // Asynchronous reset mid-stream with a source held high.
        do_write(10'd5, 4'hF, 32'hFF);
        do_write(10'd6, 4'hF, 32'hFF);
        check("pre_rst_irq", {31'b0, irq}, 32'h1);
        @(negedge clk);
        irq_src = 8'h01;
        #2 rst = 1'b1;
        #1;
        check("async_rst_irq", {31'b0, irq}, 32'h0);
        check("async_rst_gp2", gp_out[95:64], 32'h0);
        check("async_rst_rd", read_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        do_read(10'd4, 32'h01, "post_rst_status");
        do_read(10'd5, 32'h0, "post_rst_mask");
        do_write(10'd5, 4'h1, 32'h01);
        check("post_rst_irq", {31'b0, irq}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gp_reg_bank_irq.md
# gp_reg_bank_irq

Parametrised bank of memory-mapped general-purpose registers with a maskable, sticky interrupt controller, successor to the single-register GP block. Sits on the same simple read/write slave bus as the other peripheral registers; drives NUM_GP register values into the fabric and a single level interrupt line to the processor. Interrupt status is captured from rising edges of hardware event inputs and cleared by software with write-1-to-clear.

## Interface
Parameters:
- DATA_W, 32, bus and register width; multiple of 8.
- ADDR_W, 10, word address width; NUM_GP+4 ≤ 2**ADDR_W.
- NUM_GP, 4, number of GP registers; 1..64.
- IRQ_W, 8, number of interrupt sources; 1..DATA_W.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- read  in  1  read strobe, one cycle per access.
- write  in  1  write strobe, one cycle per access.
- address  in  ADDR_W  word address.
- byte_en  in  DATA_W/8  write byte enables.
- write_data  in  DATA_W  write data.
- read_data  out  DATA_W  registered read data.
- gp_out  out  NUM_GP*DATA_W  register i at bits [i*DATA_W +: DATA_W].
- irq_src  in  IRQ_W  event inputs, synchronous to clk.
- irq  out  1  level interrupt: OR of (status AND mask).

## Operation
- Register map (word addresses):
  - 0..NUM_GP-1: GP[i], R/W, byte-enabled.
  - NUM_GP+0: IRQ_STATUS, R/W1C, bits [IRQ_W-1:0]; upper bits read 0.
  - NUM_GP+1: IRQ_MASK, R/W, byte-enabled, 1 = enabled.
  - NUM_GP+2: IRQ_FORCE, write-only; each 1 bit in an enabled byte sets the status bit; reads 0.
  - NUM_GP+3: CONFIG, read-only: [7:0]=NUM_GP, [15:8]=IRQ_W, others 0.
  - Any other address: reads 0, writes ignored, no error.
- Byte enables: a byte with byte_en=0 is untouched on GP/MASK and has no effect on STATUS/FORCE.
- Edge capture: src_q holds previous irq_src. Status bit i sets when irq_src[i]=1 and src_q[i]=0. Sticky until cleared.
- Simultaneous set (edge or force) and W1C on the same bit in the same cycle: set wins.
- read and write in the same cycle to the same address: read_data returns the pre-write value.
- read_data holds its last value when read=0. Reads have no side effects.
- irq is combinational from status and mask registers only (no path from bus inputs), hence glitch-free.
- Masking never alters status; unmasking a pending bit asserts irq immediately.

## Timing
- Reset (async assert, sync-safe deassert handled upstream): GP[*]=0, status=0, mask=0, src_q=0, read_data=0, irq=0.
- A source held high through reset sets its status bit at the first rising edge after rst deasserts.
- Write: registers update at the edge where write=1; gp_out and irq reflect it the same cycle after that edge.
- Read latency 1: read=1 at edge k → read_data valid after edge k, until the next read.
- Event latency: irq_src rises before edge k → status set at edge k → irq high after edge k (if masked-in).
- W1C latency: write at edge k clears; irq drops after edge k unless a new edge arrives in the same cycle.
- Back-to-back accesses every cycle supported; no wait states, no stall.

## Structure
- Package gp_reg_bank_pkg: address offsets OFS_STATUS=0, OFS_MASK=1, OFS_FORCE=2, OFS_CONFIG=3 (relative to NUM_GP), CONFIG field positions, a byte-enable merge function.
- Sub-module irq_edge_capture (params IRQ_W): src_q, edge detect, sticky status with set-priority, W1C and force inputs, status output. Top holds GP array, mask, decode and read mux.

## Test plan
- Reset then read all addresses (NUM_GP=4): GP0..3=0, STATUS=0, MASK=0, FORCE=0, CONFIG=0x0000_0804, address 9 reads 0; irq=0.
- Write GP2=0xDEADBEEF with byte_en=4'b0101 after GP2=0x11223344 → GP2 reads 0x11AD33EF; gp_out[95:64] matches one cycle after the write.
- Pulse irq_src[3] for one cycle, MASK=0 → STATUS=0x08, irq=0; write MASK=0x08 → irq=1 the same cycle after the write; W1C 0x08 → STATUS=0, irq=0.
- W1C of bit 1 in the same cycle as an irq_src[1] rising edge → STATUS bit 1 remains 1, irq stays high.
- Write FORCE=0x81 → STATUS=0x81; read FORCE → 0; write STATUS=0x01 → STATUS=0x80.
- Assert rst mid-stream with STATUS=0xFF, MASK=0xFF, irq_src=0x01 held → irq drops immediately; after release STATUS=0x01 at the first edge.
